// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the occupancy state of the two-entry output buffer.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN  = 2'd0;
    localparam logic [1:0] MODE_ZERO  = 2'd1;
    localparam logic [1:0] MODE_LUI   = 2'd2;
    localparam logic [1:0] MODE_SHIFT = 2'd3;

    // Number of entries held: none, output register only, output plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper-immediate and
// shifted-offset forms, plus a flag for significant bits lost by the shift.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHAMT = 2
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] ext_data,
    output logic             ext_ovf
);

    // The shift keeps the value only if the bits shifted out match the new sign bit.
    localparam int unsigned TOP_W = SHAMT + 1;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_lui;
    logic [OUT_W-1:0] w_shift;
    logic [TOP_W-1:0] w_top;

    assign w_sext  = OUT_W'($signed(in_data));
    assign w_zext  = OUT_W'(in_data);
    assign w_lui   = w_zext << (OUT_W - IN_W);
    assign w_shift = w_sext << SHAMT;
    assign w_top   = w_sext[OUT_W-1 -: TOP_W];

    // Select the extended form; overflow is only meaningful for the shifted form.
    always_comb begin
        ext_data = w_sext;
        ext_ovf  = 1'b0;
        unique case (in_mode)
            MODE_SIGN:  ext_data = w_sext;
            MODE_ZERO:  ext_data = w_zext;
            MODE_LUI:   ext_data = w_lui;
            MODE_SHIFT: begin
                ext_data = w_shift;
                ext_ovf  = (|w_top) && !(&w_top);
            end
            default:    ext_data = w_sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a valid/ready handshake and a
// one-entry skid register so a downstream stall never drops an accepted value.
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHAMT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    state_t           r_state;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_skid_ovf;

    logic [OUT_W-1:0] w_ext_data;
    logic             w_ext_ovf;
    logic             w_accept;
    logic             w_emit;

    // Extension happens before storage so both registers hold final values.
    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) u_core (
        .in_data  (in_data),
        .in_mode  (in_mode),
        .ext_data (w_ext_data),
        .ext_ovf  (w_ext_ovf)
    );

    // Handshake flags decode the state register only; out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (r_state != FULL);
        out_valid = (r_state != EMPTY);
        out_data  = r_out_data;
        out_ovf   = r_out_ovf;
        w_accept  = in_valid && in_ready;
        w_emit    = out_valid && out_ready;
    end

    // Occupancy state and storage; flush drops everything, including a same-edge accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_skid_data <= '0;
            r_skid_ovf  <= 1'b0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_out_data <= w_ext_data;
                        r_out_ovf  <= w_ext_ovf;
                        r_state    <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_emit) begin
                        r_out_data <= w_ext_data;
                        r_out_ovf  <= w_ext_ovf;
                    end else if (w_accept) begin
                        // Output is stalled: park the newer entry behind it.
                        r_skid_data <= w_ext_data;
                        r_skid_ovf  <= w_ext_ovf;
                        r_state     <= FULL;
                    end else if (w_emit) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_emit) begin
                        r_out_data <= r_skid_data;
                        r_out_ovf  <= r_skid_ovf;
                        r_state    <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: default 16->32 instance plus a
// 16->16 instance for shift-overflow cases.
module tb_imm_extend_stage;
    import imm_ext_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;

    logic        v_in_valid;
    logic        v_in_ready;
    logic [15:0] v_in_data;
    logic [1:0]  v_in_mode;
    logic        v_out_valid;
    logic [15:0] v_out_data;
    logic        v_out_ovf;

    int n_checks;
    int n_errors;

    imm_extend_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    imm_extend_stage #(
        .IN_W  (16),
        .OUT_W (16),
        .SHAMT (2)
    ) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (v_in_valid),
        .in_ready  (v_in_ready),
        .in_data   (v_in_data),
        .in_mode   (v_in_mode),
        .out_valid (v_out_valid),
        .out_ready (1'b1),
        .out_data  (v_out_data),
        .out_ovf   (v_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one entry with out_ready=1; it must appear right after the accepting edge.
    task automatic send_one(input string tag, input logic [1:0] mode, input logic [15:0] data,
                            input logic [31:0] exp_data, input logic exp_ovf);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_data   = data;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, out_data, exp_data);
        check({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
    endtask

    task automatic send_v(input string tag, input logic [15:0] data,
                          input logic [15:0] exp_data, input logic exp_ovf);
        v_in_valid = 1'b1;
        v_in_mode  = MODE_SHIFT;
        v_in_data  = data;
        step();
        v_in_valid = 1'b0;
        check({tag, ".valid"}, 32'(v_out_valid), 32'd1);
        check({tag, ".data"}, 32'(v_out_data), 32'(exp_data));
        check({tag, ".ovf"}, 32'(v_out_ovf), 32'(exp_ovf));
    endtask

    // Fill both entries under backpressure with two SIGN values.
    task automatic fill_full(input logic [15:0] a, input logic [15:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = MODE_SIGN;
        in_data   = a;
        step();
        in_data = b;
        step();
        in_valid = 1'b0;
        check("fill.in_ready_low", 32'(in_ready), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mode    = MODE_SIGN;
        out_ready  = 1'b1;
        v_in_valid = 1'b0;
        v_in_data  = '0;
        v_in_mode  = MODE_SHIFT;

        #3;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_data", out_data, 32'd0);
        check("rst.out_ovf", 32'(out_ovf), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        send_one("sign_pos", MODE_SIGN, 16'h7FFF, 32'h0000_7FFF, 1'b0);
        send_one("sign_neg", MODE_SIGN, 16'hFDFF, 32'hFFFF_FDFF, 1'b0);
        send_one("zero", MODE_ZERO, 16'hFDFF, 32'h0000_FDFF, 1'b0);
        send_one("lui", MODE_LUI, 16'h1234, 32'h1234_0000, 1'b0);
        send_one("shift_neg", MODE_SHIFT, 16'hFFFF, 32'hFFFF_FFFC, 1'b0);
        send_one("shift_pos", MODE_SHIFT, 16'h4000, 32'h0001_0000, 1'b0);
        step();
        check("drain.empty", 32'(out_valid), 32'd0);

        send_v("v16_ovf", 16'h4000, 16'h0000, 1'b1);
        send_v("v16_ok", 16'hE000, 16'h8000, 1'b0);

        // Backpressure: A, B accepted, C held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = MODE_SIGN;
        in_data   = 16'd1;
        step();
        check("bp.a_in_ready", 32'(in_ready), 32'd1);
        check("bp.a_data", out_data, 32'd1);
        in_data = 16'd2;
        step();
        check("bp.b_in_ready", 32'(in_ready), 32'd0);
        in_data = 16'd3;
        step();
        check("bp.c_held", 32'(in_ready), 32'd0);
        check("bp.stable_data", out_data, 32'd1);
        check("bp.stable_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        check("bp.out_a", out_data, 32'd1);
        step();
        check("bp.out_b", out_data, 32'd2);
        check("bp.b_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp.out_c", out_data, 32'd3);
        check("bp.c_valid", 32'(out_valid), 32'd1);
        step();
        check("bp.empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL, asserted between edges.
        fill_full(16'h0055, 16'h0066);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.out_data", out_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_one("arst.after", MODE_SIGN, 16'h0001, 32'h0000_0001, 1'b0);
        step();
        check("arst.drained", 32'(out_valid), 32'd0);

        // Flush while FULL with a same-edge accept.
        fill_full(16'h0011, 16'h0022);
        in_valid = 1'b1;
        in_data  = 16'h0033;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush.no_stale", 32'(out_valid), 32'd0);
        end
        send_one("flush.after", MODE_ZERO, 16'h8001, 32'h0000_8001, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
